// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus arbiter: bus mode encoding,
// arbiter FSM state type and peripheral base addresses.
package periph_bus_pkg;

    localparam logic [1:0] MD_READ  = 2'b00;
    localparam logic [1:0] MD_WRITE = 2'b01;
    localparam logic [1:0] MD_IDLE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    localparam logic [23:0] UART_BASE = 24'h200000;
    localparam logic [23:0] SIE_BASE  = 24'h210000;
    localparam logic [23:0] HID_BASE  = 24'h220000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. Returns one-hot grant, its index and an any flag.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan N candidates starting at ptr; the first hit wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral register bus between masters.
// One registered transaction per grant: IDLE (arbitrate) -> ISSUE (bus
// active one cycle) -> DONE (ack to winner).
// Optional macro PERIPH_ARB_LOCK_EN: lock_i[winner] keeps ownership across
// transactions for atomic multi-register accesses; otherwise lock_i is ignored.
//
// state | meaning
// IDLE  | no bus activity, arbitrate among requesters
// ISSUE | latched op presented on the bus for exactly one cycle
// DONE  | ack pulse to the winner, advance round-robin pointer
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                          clk_i,
    input  logic                          rstn,
    input  logic [NUM_MASTERS-1:0]        req_i,
    input  logic [NUM_MASTERS-1:0]        wr_i,
    input  logic [NUM_MASTERS-1:0]        lock_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] wdata_i,
    output logic [NUM_MASTERS-1:0]        ack_o,
    output logic [DATA_W-1:0]             rdata_o,
    output logic [NUM_MASTERS-1:0]        grant_o,
    output logic [ADDR_W-1:0]             bus_ad_o,
    output logic [DATA_W-1:0]             bus_do_o,
    output logic [1:0]                    bus_md_o,
    input  logic [DATA_W-1:0]             bus_di_i
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    arb_state_e             state, state_nxt;
    logic [IDX_W-1:0]       owner, ptr, ptr_inc;
    logic [IDX_W-1:0]       pick_ptr, pick_idx;
    logic [NUM_MASTERS-1:0] pick_req, unused_pick_gnt;
    logic                   pick_any;
    logic                   wr_q;
    logic                   locked;

    assign ptr_inc = (owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;

    // Picker inputs: plain round-robin, or restricted to the locked owner.
    always_comb begin
        pick_req = req_i;
        pick_ptr = ptr;
`ifdef PERIPH_ARB_LOCK_EN
        if (locked) begin
            if (lock_i[owner]) begin
                pick_req = req_i & (NUM_MASTERS'(1) << owner);
                pick_ptr = owner;
            end else begin
                pick_ptr = ptr_inc;
            end
        end
`endif
    end

    rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .gnt (unused_pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifndef PERIPH_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^lock_i;
`endif

    // Next state and bus/handshake outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        bus_md_o  = MD_IDLE;
        grant_o   = '0;
        ack_o     = '0;
        case (state)
            ST_IDLE:  if (pick_any) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                state_nxt = ST_DONE;
                bus_md_o  = wr_q ? MD_WRITE : MD_READ;
            end
            ST_DONE: begin
                state_nxt    = ST_IDLE;
                ack_o[owner] = 1'b1;
            end
            default:  state_nxt = ST_IDLE;
        endcase
        if (state != ST_IDLE) grant_o[owner] = 1'b1;
    end

    // State register, transaction latch, read capture and pointer update.
    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            owner    <= '0;
            ptr      <= '0;
            wr_q     <= 1'b0;
            locked   <= 1'b0;
            bus_ad_o <= '0;
            bus_do_o <= '0;
            rdata_o  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
`ifdef PERIPH_ARB_LOCK_EN
                    if (locked && !lock_i[owner]) begin
                        locked <= 1'b0;
                        ptr    <= ptr_inc;
                    end
`endif
                    if (pick_any) begin
                        owner    <= pick_idx;
                        wr_q     <= wr_i[pick_idx];
                        bus_ad_o <= addr_i[pick_idx*ADDR_W +: ADDR_W];
                        bus_do_o <= wdata_i[pick_idx*DATA_W +: DATA_W];
                    end
                end
                ST_ISSUE: if (!wr_q) rdata_o <= bus_di_i;
                ST_DONE: begin
`ifdef PERIPH_ARB_LOCK_EN
                    if (lock_i[owner]) locked <= 1'b1;
                    else               ptr    <= ptr_inc;
`else
                    ptr <= ptr_inc;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed self-checking bench for periph_bus_arbiter (2 masters, 32-bit).
module tb_periph_bus_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn;
    logic [1:0]  req_i, wr_i, lock_i;
    logic [63:0] addr_i, wdata_i;
    logic [1:0]  ack_o, grant_o, bus_md_o;
    logic [31:0] rdata_o, bus_ad_o, bus_do_o, bus_di_i;

    int n_cmp = 0;
    int n_err = 0;

    periph_bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i    (clk_i),
        .rstn     (rstn),
        .req_i    (req_i),
        .wr_i     (wr_i),
        .lock_i   (lock_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .ack_o    (ack_o),
        .rdata_o  (rdata_o),
        .grant_o  (grant_o),
        .bus_ad_o (bus_ad_o),
        .bus_do_o (bus_do_o),
        .bus_md_o (bus_md_o),
        .bus_di_i (bus_di_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus_md_o !== 2'b11) begin n_err++; $display("FAIL reset_md got %b want 11", bus_md_o); end
        n_cmp++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL reset_grant got %b want 00", grant_o); end
        n_cmp++; if (ack_o !== 2'b00) begin n_err++; $display("FAIL reset_ack got %b want 00", ack_o); end
        n_cmp++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
        n_cmp++; if (bus_ad_o !== 32'h0 || bus_do_o !== 32'h0) begin n_err++; $display("FAIL reset_addr_data got %h/%h want 0/0", bus_ad_o, bus_do_o); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        addr_i[31:0] = 32'h2200_0004;
        wr_i         = 2'b00;
        bus_di_i     = 32'hDEAD_BEEF;
        req_i        = 2'b01;
        tick();
        n_cmp++; if (bus_md_o !== 2'b00) begin n_err++; $display("FAIL read_md got %b want 00", bus_md_o); end
        n_cmp++; if (bus_ad_o !== 32'h2200_0004) begin n_err++; $display("FAIL read_addr got %h want 22000004", bus_ad_o); end
        n_cmp++; if (grant_o !== 2'b01 || ack_o !== 2'b00) begin n_err++; $display("FAIL read_issue_grant got %b/%b want 01/00", grant_o, ack_o); end
        tick();
        n_cmp++; if (ack_o !== 2'b01) begin n_err++; $display("FAIL read_ack got %b want 01", ack_o); end
        n_cmp++; if (rdata_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL read_rdata got %h want deadbeef", rdata_o); end
        n_cmp++; if (bus_md_o !== 2'b11) begin n_err++; $display("FAIL read_done_md got %b want 11", bus_md_o); end
        req_i = 2'b00;
        tick();
        n_cmp++; if (ack_o !== 2'b00 || grant_o !== 2'b00) begin n_err++; $display("FAIL read_idle got ack %b grant %b want 00/00", ack_o, grant_o); end
    endtask

    task automatic test_single_write();
        int writes = 0;
        addr_i[63:32]  = 32'h2100_0008;
        wdata_i[63:32] = 32'h1234_5678;
        wr_i           = 2'b10;
        bus_di_i       = 32'hCAFE_F00D;
        req_i          = 2'b10;
        tick();
        if (bus_md_o === 2'b01) writes++;
        n_cmp++; if (bus_md_o !== 2'b01) begin n_err++; $display("FAIL write_md got %b want 01", bus_md_o); end
        n_cmp++; if (bus_ad_o !== 32'h2100_0008 || bus_do_o !== 32'h1234_5678) begin n_err++; $display("FAIL write_bus got %h/%h want 21000008/12345678", bus_ad_o, bus_do_o); end
        n_cmp++; if (grant_o !== 2'b10) begin n_err++; $display("FAIL write_grant got %b want 10", grant_o); end
        addr_i[63:32] = 32'h0000_0000;
        tick();
        if (bus_md_o === 2'b01) writes++;
        n_cmp++; if (ack_o !== 2'b10) begin n_err++; $display("FAIL write_ack got %b want 10", ack_o); end
        n_cmp++; if (rdata_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL write_rdata_hold got %h want deadbeef", rdata_o); end
        req_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_md_o === 2'b01) writes++;
        end
        n_cmp++; if (writes != 1) begin n_err++; $display("FAIL write_count got %0d want 1", writes); end
        wr_i = 2'b00;
    endtask

    task automatic test_contention();
        int acks = 0, multi = 0, cyc = 0, last_cyc = 0, bad_order = 0;
        logic [1:0] exp_ack = 2'b01;
        addr_i   = {32'h2100_0020, 32'h2000_0010};
        bus_di_i = 32'h0BAD_F00D;
        wr_i     = 2'b00;
        req_i    = 2'b11;
        while (acks < 12 && cyc < 60) begin
            tick();
            cyc++;
            if (grant_o == 2'b11) multi++;
            if (ack_o != 2'b00) begin
                if (ack_o !== exp_ack || rdata_o !== 32'h0BAD_F00D) begin
                    bad_order++;
                    $display("FAIL contention_ack%0d got %b rdata %h want %b 0badf00d", acks, ack_o, rdata_o, exp_ack);
                end
                exp_ack  = {exp_ack[0], exp_ack[1]};
                acks++;
                last_cyc = cyc;
                if (acks == 12) req_i = 2'b00;
            end
        end
        n_cmp++; if (acks != 12) begin n_err++; $display("FAIL contention_acks got %0d want 12", acks); end
        n_cmp++; if (bad_order != 0) begin n_err++; $display("FAIL contention_order got %0d bad want 0", bad_order); end
        n_cmp++; if (multi != 0) begin n_err++; $display("FAIL contention_multi_grant got %0d want 0", multi); end
        n_cmp++; if (last_cyc != 35) begin n_err++; $display("FAIL contention_rate got %0d want 35", last_cyc); end
        tick();
    endtask

    task automatic test_early_drop();
        req_i = 2'b01;
        tick();
        n_cmp++; if (grant_o !== 2'b01) begin n_err++; $display("FAIL drop_grant0 got %b want 01", grant_o); end
        req_i = 2'b10;
        tick();
        n_cmp++; if (ack_o !== 2'b01) begin n_err++; $display("FAIL drop_ack0 got %b want 01", ack_o); end
        tick();
        n_cmp++; if (grant_o !== 2'b00) begin n_err++; $display("FAIL drop_idle got %b want 00", grant_o); end
        tick();
        n_cmp++; if (grant_o !== 2'b10) begin n_err++; $display("FAIL drop_grant1 got %b want 10", grant_o); end
        tick();
        n_cmp++; if (ack_o !== 2'b10) begin n_err++; $display("FAIL drop_ack1 got %b want 10", ack_o); end
        req_i = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_op();
        // pointer ends at 1 after a master0 transaction
        req_i = 2'b01;
        tick();
        tick();
        req_i = 2'b00;
        tick();
        req_i = 2'b11;
        tick();
        n_cmp++; if (grant_o !== 2'b10 || bus_md_o !== 2'b00) begin n_err++; $display("FAIL rst_pre_grant got %b md %b want 10/00", grant_o, bus_md_o); end
        rstn = 1'b0;
        tick();
        n_cmp++; if (bus_md_o !== 2'b11 || grant_o !== 2'b00 || ack_o !== 2'b00) begin n_err++; $display("FAIL rst_mid got md %b grant %b ack %b want 11/00/00", bus_md_o, grant_o, ack_o); end
        n_cmp++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_rdata got %h want 0", rdata_o); end
        rstn = 1'b1;
        tick();
        n_cmp++; if (grant_o !== 2'b01 || ack_o !== 2'b00) begin n_err++; $display("FAIL rst_ptr got grant %b ack %b want 01/00", grant_o, ack_o); end
        tick();
        n_cmp++; if (ack_o !== 2'b01) begin n_err++; $display("FAIL rst_after_ack got %b want 01", ack_o); end
        req_i = 2'b00;
        tick();
    endtask

`ifdef PERIPH_ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] exp_order [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
        int acks = 0, cyc = 0, bad = 0;
        logic armed = 1'b0;
        lock_i = 2'b01;
        req_i  = 2'b01;
        tick();
        req_i = 2'b11;
        while (acks < 4 && cyc < 40) begin
            if (cyc > 0) tick();
            cyc++;
            if (armed && grant_o == 2'b01 && ack_o == 2'b00) begin
                lock_i = 2'b00;
                armed  = 1'b0;
            end
            if (ack_o != 2'b00) begin
                if (ack_o !== exp_order[acks]) begin
                    bad++;
                    $display("FAIL lock_ack%0d got %b want %b", acks, ack_o, exp_order[acks]);
                end
                acks++;
                if (acks == 2) armed = 1'b1;
            end
        end
        n_cmp++; if (acks != 4) begin n_err++; $display("FAIL lock_acks got %0d want 4", acks); end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL lock_order got %0d bad want 0", bad); end
        req_i  = 2'b00;
        lock_i = 2'b00;
        tick();
        tick();
    endtask
`endif

    initial begin
        rstn     = 1'b0;
        req_i    = '0;
        wr_i     = '0;
        lock_i   = '0;
        addr_i   = '0;
        wdata_i  = '0;
        bus_di_i = '0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_early_drop();
        test_reset_mid_op();
`ifdef PERIPH_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
